// File: rtl/layer_argmax_pkg.sv
// Shared defaults and FSM encoding for the layer_argmax classifier head.
package layer_argmax_pkg;

  localparam int unsigned N_IN_DEF  = 15;
  localparam int unsigned ACT_W_DEF = 8;
  localparam int unsigned IDX_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/layer_argmax.sv
// Sequential signed argmax over one captured activation vector; one element per cycle,
// lowest index wins on ties, result held with a valid/ready handshake.
module layer_argmax
  import layer_argmax_pkg::*;
#(
  parameter int unsigned N_IN  = N_IN_DEF,
  parameter int unsigned ACT_W = ACT_W_DEF,
  parameter int unsigned IDX_W = IDX_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_IN*ACT_W-1:0]   act_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [IDX_W-1:0]        class_idx,
  output logic [ACT_W-1:0]        class_val,
  output logic                    class_tie
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);

  state_t state, state_nxt;

  logic signed [ACT_W-1:0] elem [N_IN];
  logic signed [ACT_W-1:0] best;
  logic        [IDX_W-1:0] best_idx;
  logic                    tie;
  logic        [IDX_W-1:0] cnt;

  logic                    cap_c;
  logic                    step_c;
  logic                    last_c;
  logic signed [ACT_W-1:0] cur_c;
  logic signed [ACT_W-1:0] best_nxt;
  logic        [IDX_W-1:0] idx_nxt;
  logic                    tie_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, control strobes and the single-element compare step
  always_comb begin
    state_nxt = state;
    cap_c     = 1'b0;
    step_c    = 1'b0;
    last_c    = 1'b0;
    cur_c     = elem[cnt];
    best_nxt  = best;
    idx_nxt   = best_idx;
    tie_nxt   = tie;

    if (cur_c > best) begin
      best_nxt = cur_c;
      idx_nxt  = cnt;
      tie_nxt  = 1'b0;
    end else if (cur_c == best) begin
      tie_nxt  = 1'b1;
    end

    case (state)
      IDLE: begin
        if (in_valid) begin
          cap_c     = 1'b1;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        step_c = 1'b1;
        if (cnt == LAST_IDX) begin
          last_c    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake flags track the upcoming state so they are registered yet state-exact
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
    end
  end

  // Captured vector, running best and published result
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_IN; i++) begin
        elem[i] <= '0;
      end
      best      <= '0;
      best_idx  <= '0;
      tie       <= 1'b0;
      cnt       <= '0;
      class_idx <= '0;
      class_val <= '0;
      class_tie <= 1'b0;
    end else begin
      if (cap_c) begin
        for (int unsigned i = 0; i < N_IN; i++) begin
          elem[i] <= act_in[i*ACT_W +: ACT_W];
        end
        best     <= act_in[ACT_W-1:0];
        best_idx <= '0;
        tie      <= 1'b0;
        cnt      <= IDX_W'(1);
      end else if (step_c) begin
        best     <= best_nxt;
        best_idx <= idx_nxt;
        tie      <= tie_nxt;
        cnt      <= cnt + IDX_W'(1);
      end
      if (last_c) begin
        class_idx <= idx_nxt;
        class_val <= best_nxt;
        class_tie <= tie_nxt;
      end
    end
  end

endmodule

// File: tb/tb_layer_argmax.sv
// Directed and randomized checks of layer_argmax against a plain argmax reference model.
module tb_layer_argmax;
  import layer_argmax_pkg::*;

  localparam int unsigned N = N_IN_DEF;
  localparam int unsigned W = ACT_W_DEF;
  localparam int unsigned I = IDX_W_DEF;

  logic           clk = 1'b0;
  logic           reset;
  logic [N*W-1:0] act_in;
  logic           in_valid;
  logic           in_ready;
  logic           out_valid;
  logic           out_ready;
  logic [I-1:0]   class_idx;
  logic [W-1:0]   class_val;
  logic           class_tie;

  int checks = 0;
  int errors = 0;
  int vec [N];

  layer_argmax #(.N_IN(N), .ACT_W(W), .IDX_W(I)) dut (
    .clk       (clk),
    .reset     (reset),
    .act_in    (act_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .class_idx (class_idx),
    .class_val (class_val),
    .class_tie (class_tie)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*W-1:0] pack_vec();
    logic [N*W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'(vec[i]);
    return r;
  endfunction

  // Reference: first strictly-greater signed value wins; tie when the max occurs more than once
  task automatic model(output int idx, output int val, output int tie);
    int sv [N];
    int mx;
    int hits;
    for (int i = 0; i < N; i++)
      sv[i] = (vec[i] >= (1 << (W - 1))) ? vec[i] - (1 << W) : vec[i];
    mx  = sv[0];
    idx = 0;
    for (int i = 1; i < N; i++)
      if (sv[i] > mx) begin
        mx  = sv[i];
        idx = i;
      end
    hits = 0;
    for (int i = 0; i < N; i++) if (sv[i] == mx) hits++;
    tie = (hits > 1) ? 1 : 0;
    val = mx & ((1 << W) - 1);
  endtask

  task automatic capture(input string tag);
    act_in   = pack_vec();
    in_valid = 1'b1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk({tag, "_busy"}, 32'(in_ready), 32'd0);
  endtask

  task automatic await_result(input string tag);
    int lat;
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), N - 1);
  endtask

  task automatic check_model(input string tag);
    int e_idx, e_val, e_tie;
    model(e_idx, e_val, e_tie);
    chk({tag, "_idx"}, 32'(class_idx), 32'(e_idx));
    chk({tag, "_val"}, 32'(class_val), 32'(e_val));
    chk({tag, "_tie"}, 32'(class_tie), 32'(e_tie));
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_ov_low"}, 32'(out_valid), 32'd0);
    chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  task automatic run_vec(input string tag);
    capture(tag);
    await_result(tag);
    check_model(tag);
    handshake(tag);
  endtask

  initial begin
    int seen_ov;
    logic [I-1:0] h_idx;
    logic [W-1:0] h_val;
    logic         h_tie;

    reset     = 1'b1;
    act_in    = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_idx", 32'(class_idx), 32'd0);
    chk("rst_val", 32'(class_val), 32'd0);
    chk("rst_tie", 32'(class_tie), 32'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Ramp: maximum at the last element
    for (int i = 0; i < N; i++) vec[i] = 5 * i;
    run_vec("ramp");
    chk("ramp_idx_const", 32'(class_idx), 32'd14);
    chk("ramp_val_const", 32'(class_val), 32'd70);

    // Two equal maxima: lowest index reported with tie flag
    for (int i = 0; i < N; i++) vec[i] = 10;
    vec[3] = 127;
    vec[9] = 127;
    run_vec("tie");
    chk("tie_idx_const", 32'(class_idx), 32'd3);
    chk("tie_tie_const", 32'(class_tie), 32'd1);

    // All negative: -1 beats -16
    for (int i = 0; i < N; i++) vec[i] = 'hF0;
    vec[7] = 'hFF;
    run_vec("neg");
    chk("neg_idx_const", 32'(class_idx), 32'd7);
    chk("neg_val_const", 32'(class_val), 32'hFF);

    // Backpressure: result held, new vectors ignored while DONE
    for (int i = 0; i < N; i++) vec[i] = $urandom_range(0, 255);
    capture("bp");
    await_result("bp");
    check_model("bp");
    h_idx = class_idx;
    h_val = class_val;
    h_tie = class_tie;
    for (int c = 0; c < 5; c++) begin
      act_in   = {N{8'h7F}};
      in_valid = 1'b1;
      tick();
      chk("bp_hold_ov", 32'(out_valid), 32'd1);
      chk("bp_hold_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_idx", 32'(class_idx), 32'(h_idx));
      chk("bp_hold_val", 32'(class_val), 32'(h_val));
      chk("bp_hold_tie", 32'(class_tie), 32'(h_tie));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("bp_after_ready", 32'(in_ready), 32'd1);
    chk("bp_after_ov", 32'(out_valid), 32'd0);
    tick();
    chk("bp_no_capture", 32'(in_ready), 32'd1);
    chk("bp_idle_idx", 32'(class_idx), 32'(h_idx));
    chk("bp_idle_val", 32'(class_val), 32'(h_val));

    // Reset mid-scan discards the vector
    for (int i = 0; i < N; i++) vec[i] = 200 - i;
    capture("rst_scan");
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_scan_idx", 32'(class_idx), 32'd0);
    chk("rst_scan_val", 32'(class_val), 32'd0);
    seen_ov = 0;
    for (int c = 0; c < 25; c++) begin
      if (out_valid) seen_ov++;
      tick();
    end
    chk("rst_scan_no_ov", 32'(seen_ov), 32'd0);
    chk("rst_scan_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < N; i++) vec[i] = 0;
    run_vec("zero");
    chk("zero_idx_const", 32'(class_idx), 32'd0);
    chk("zero_tie_const", 32'(class_tie), 32'd1);

    // Randomized vectors; narrow ranges provoke ties
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < N; i++)
        vec[i] = (t % 3 == 0) ? int'($urandom_range(0, 3)) + 'hFC * (t % 2)
                              : int'($urandom_range(0, 255));
      run_vec("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/layer_argmax.md
LAYER_ARGMAX -- requirements
Module: layer_argmax

Interface
REQ-001 The block SHALL have parameter N_IN, default 15, number of activations per vector.
REQ-002 The block SHALL have parameter ACT_W, default 8, activation width, two's-complement signed.
REQ-003 The block SHALL have parameter IDX_W, default 4, class-index width, with 2^IDX_W >= N_IN.
REQ-004 The block SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-005 The block SHALL have port reset, input, 1 bit: reset is synchronous and active-high; clock is clk.
REQ-006 The block SHALL have port act_in, input, N_IN*ACT_W bits, the flat activation vector; element i sits at bits [i*ACT_W+ACT_W-1 : i*ACT_W].
REQ-007 The block SHALL have port in_valid, input, 1 bit, meaning act_in is valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit, meaning the block can accept a vector.
REQ-009 The block SHALL have port out_valid, output, 1 bit, meaning a result is available.
REQ-010 The block SHALL have port out_ready, input, 1 bit, meaning the consumer accepts the result.
REQ-011 The block SHALL have port class_idx, output, IDX_W bits, the index of the maximum element.
REQ-012 The block SHALL have port class_val, output, ACT_W bits, the value of the maximum element.
REQ-013 The block SHALL have port class_tie, output, 1 bit: 1 when at least one other element equals the maximum.

Function
REQ-014 The FSM SHALL have three states: IDLE, SCAN and DONE.
REQ-015 In IDLE, in_ready SHALL be 1; in SCAN and DONE, in_ready SHALL be 0.
REQ-016 On a clock edge with in_valid=1 and in_ready=1, the block SHALL register all N_IN elements, load best=elem0, best_idx=0, tie=0 and cnt=1, and go to SCAN.
REQ-017 In SCAN, each edge SHALL compare elem[cnt] as a signed value against best: if greater, load best/best_idx and clear tie; if equal, set tie; if less, hold.
REQ-018 cnt SHALL then increment; the edge that processes cnt=N_IN-1 SHALL move the FSM to DONE.
REQ-019 out_valid SHALL rise exactly N_IN-1 edges after the capture edge (14 for the defaults).
REQ-020 In DONE, out_valid SHALL be 1, and class_idx, class_val and class_tie SHALL stay stable until the out_ready=1 edge, which returns the FSM to IDLE.
REQ-021 Ties SHALL resolve to the lowest index.
REQ-022 in_valid SHALL be ignored outside IDLE.
REQ-023 There SHALL be no capture on the same edge that completes an output handshake; the result is a one-cycle bubble.
REQ-024 While out_valid=0, the result outputs SHALL hold their last value.
REQ-025 The registered input copy SHALL NOT change between capture and the DONE handshake.

Reset
REQ-026 While reset is high, the FSM SHALL go to IDLE, with out_valid=0, class_idx=0, class_val=0, class_tie=0, cnt=0 and all captured elements=0.
REQ-027 in_ready SHALL be 1 on the first cycle after reset deasserts.
REQ-028 Reset asserted during SCAN or DONE SHALL discard the vector, and out_valid SHALL NOT assert for it.

Structure
REQ-029 A shared package SHALL hold N_IN, ACT_W and IDX_W defaults and the FSM state enum.
REQ-030 The block SHALL be a single module with no sub-module; the compare step is inline.
REQ-031 All registers SHALL use clk and the synchronous reset.

Verification
REQ-032 Ramp test: elem[i]=5*i -> class_idx=14, class_val=70, class_tie=0, with out_valid 14 cycles after capture.
REQ-033 Tie test: elem3=elem9=127, all others 10 -> class_idx=3, class_val=127, class_tie=1.
REQ-034 Negative test: all elements 0xF0 except elem7=0xFF -> class_idx=7, class_val=0xFF.
REQ-035 Backpressure test: hold out_ready=0 for 5 cycles in DONE and pulse in_valid -> outputs stable and in_ready=0; after the handshake edge, in_ready=1.
REQ-036 Reset test: assert reset at cnt=6 -> out_valid never rises; a subsequent all-zero vector -> class_idx=0, class_val=0, class_tie=1.
